io_port_bank: RTL and testbench

// - Parametrised 8085-style I/O bus slave: register bank decoded in the I/O space, driven by ALE/IOM/RD/WR bus cycles.
// - Sits on the shared CPU bus beside the memory blocks; claims only I/O cycles whose address falls in its window.
// - Adds configurable width and depth, a base-address window, wait-state insertion via READY, and a single-cycle write strobe.
// - Adds a sticky bus-error flag.

---
 rtl/io_bus_pkg.sv | 34 +++
 rtl/io_wait_ctr.sv | 31 +++
 rtl/io_port_bank.sv | 137 +++++++++++++
 tb/tb_io_port_bank.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_pkg.sv
// Shared types for the 8085-style I/O bus slave: bus-cycle states,
// transfer direction and the address-window test.
package io_bus_pkg;

  typedef enum logic [5:0] {
    T1   = 6'b000001,
    T2   = 6'b000010,
    TW   = 6'b000100,
    T3_R = 6'b001000,
    T3_W = 6'b010000,
    T4   = 6'b100000
  } io_state_e;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } io_dir_e;

  localparam int CTR_W = 4;

  // Extra top bit so base+depth cannot wrap at the top of the space.
  function automatic logic in_window(
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic [31:0] depth
  );
    logic [32:0] a, lo, hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = {1'b0, base} + {1'b0, depth};
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/io_wait_ctr.sv
// Loadable wait-state down-counter; done_o is high while the count is zero.
module io_wait_ctr #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/io_port_bank.sv
// I/O-space register bank driven by ALE/IOM/RD/WR bus cycles.
// Build with IO_WAIT_EN to add the TW wait state and READY throttling.
module io_port_bank
  import io_bus_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter int              DATA_W   = 8,
  parameter logic [ADDR_W-1:0] BASE   = 16'h1C00,
  parameter int              DEPTH    = 64,
  parameter int              WAIT_CYC = 2
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              ALE,
  input  logic              IOM,
  input  logic              RD,
  input  logic              WR,
  input  logic [ADDR_W-1:0] Address,
  inout  wire  [DATA_W-1:0] Data,
  output logic              READY,
  output logic              BUSY,
  output logic              ERR
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [CTR_W-1:0] WLOAD =
    CTR_W'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

  io_state_e   state_q, state_d;
  io_dir_e     dir_q, dir_d;
  logic [IW-1:0] idx_q, idx_d;
  logic        err_q, err_d;
  logic        busy_q;
  logic        hit, wr_en, oe;
  logic        wait_go, wait_done;
  logic [DATA_W-1:0] regs_q [DEPTH];

  assign hit = ALE && IOM &&
               in_window(32'(Address), 32'(BASE), 32'(DEPTH));

`ifdef IO_WAIT_EN
  logic ctr_load;

  assign wait_go  = (WAIT_CYC > 0);
  assign ctr_load = (state_q == T2) && !ALE && !(RD && WR);
  assign READY    = (state_q != TW);

  io_wait_ctr #(
    .W (CTR_W)
  ) u_wait (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .load_i (ctr_load),
    .val_i  (WLOAD),
    .done_o (wait_done)
  );
`else
  logic unused_cfg;

  assign wait_go    = 1'b0;
  assign wait_done  = 1'b1;
  assign READY      = 1'b1;
  assign unused_cfg = ^WLOAD;
`endif

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    idx_d   = idx_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    unique case (1'b1)
      (state_q == T1): begin
        if (hit) begin
          state_d = T2;
          idx_d   = Address[IW-1:0];
        end
      end
      (state_q == T2): begin
        if (ALE) begin
          state_d = T1;
        end else if (!RD) begin
          dir_d   = DIR_RD;
          err_d   = err_q | !WR;
          state_d = wait_go ? TW : T3_R;
        end else if (!WR) begin
          dir_d   = DIR_WR;
          state_d = wait_go ? TW : T3_W;
        end
      end
      (state_q == TW): begin
        if (wait_done)
          state_d = (dir_q == DIR_RD) ? T3_R : T3_W;
      end
      (state_q == T3_R): state_d = T4;
      (state_q == T3_W): begin
        state_d = T4;
        if (!WR) wr_en = 1'b1;
        else     err_d = 1'b1;
      end
      (state_q == T4): state_d = T1;
      default: state_d = T1;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= T1;
      dir_q   <= DIR_RD;
      idx_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      busy_q  <= (state_d != T1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++)
        regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[idx_q] <= Data;
    end
  end

  // Enable follows RD directly so the bus floats as soon as RD rises.
  assign oe   = (state_q == T3_R) && !RD;
  assign Data = oe ? regs_q[idx_q] : 'z;
  assign BUSY = busy_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_io_port_bank.sv
// Randomized and directed bench for io_port_bank against a
// behavioural model of the register bank and error flag.
module tb_io_port_bank;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam logic [AW-1:0] BASE = 16'h1C00;
  localparam int WC = 2;
`ifdef IO_WAIT_EN
  localparam int DEPTH = 64;
  localparam int EXP_W = WC;
`else
  localparam int DEPTH = 512;
  localparam int EXP_W = 0;
`endif
  localparam logic [DW-1:0] FLOAT = '1;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          ALE, IOM, RD, WR;
  logic [AW-1:0] Address;
  wire  [DW-1:0] Data;
  logic          READY, BUSY, ERR;
  logic          drv_en;
  logic [DW-1:0] drv_val;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [DEPTH];
  logic          exp_err;

  assign Data = drv_en ? drv_val : 'z;

  for (genvar g = 0; g < DW; g++) begin : g_pu
    pullup (Data[g]);
  end

  always #5 CLK = ~CLK;

  io_port_bank #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .BASE     (BASE),
    .DEPTH    (DEPTH),
    .WAIT_CYC (WC)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .ALE     (ALE),
    .IOM     (IOM),
    .RD      (RD),
    .WR      (WR),
    .Address (Address),
    .Data    (Data),
    .READY   (READY),
    .BUSY    (BUSY),
    .ERR     (ERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ALE = 1'b0; IOM = 1'b0; RD = 1'b1; WR = 1'b1;
    drv_en = 1'b0; drv_val = '0; Address = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    exp_err = 1'b0;
  endtask

  // kind: 0 read, 1 write, 2 read+write strobes together
  task automatic bus(input logic [AW-1:0] a, input bit iom,
                     input int kind, input logic [DW-1:0] wd,
                     input bit early, input int hold);
    bit hit;
    int idx, waits, busy_n;
    hit = iom && (int'(a) >= int'(BASE)) &&
          (int'(a) < int'(BASE) + DEPTH);
    idx = int'(a) - int'(BASE);
    busy_n = 0;
    ALE = 1'b1; IOM = iom; Address = a;
    @(negedge CLK);
    if (BUSY) busy_n++;
    ALE = 1'b0; Address = 16'($urandom);
    if (kind != 1) RD = 1'b0;
    if (kind != 0) WR = 1'b0;
    if (kind == 1) begin drv_en = 1'b1; drv_val = 8'($urandom); end
    waits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK); #1;
      if (BUSY) busy_n++;
      if (READY) break;
      waits++;
      if (kind == 1) drv_val = 8'($urandom);
    end
    chk("wait_cycles", waits, hit ? EXP_W : 0);
    if (kind != 1) begin
      chk("rd_data", Data, hit ? mem[idx] : FLOAT);
      if (kind == 0) begin
        RD = 1'b1; #1;
        chk("rd_release", Data, FLOAT);
      end
      if (hit && kind == 2) exp_err = 1'b1;
    end else begin
      drv_val = wd;
      if (early) WR = 1'b1;
      if (hit) begin
        if (early) exp_err = 1'b1;
        else       mem[idx] = wd;
      end
    end
    @(negedge CLK);
    if (BUSY) busy_n++;
    for (int i = 0; i < hold; i++) begin
      drv_val = 8'($urandom);
      @(negedge CLK);
      if (BUSY) busy_n++;
    end
    RD = 1'b1; WR = 1'b1; drv_en = 1'b0;
    @(negedge CLK);
    if (BUSY) busy_n++;
    chk("busy_cycles", busy_n, hit ? 3 + EXP_W : 0);
    chk("err_flag", ERR, exp_err);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    chk("rst_ready", READY, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_err", ERR, 0);
    chk("rst_data", Data, FLOAT);
    model_reset();
    idle();
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    int w;
    logic [AW-1:0] a;
    idle();
    model_reset();
    RESET_N = 1'b1;
    do_reset();

    for (int i = 0; i < DEPTH; i++)
      bus(BASE + AW'(i), 1'b1, 0, '0, 1'b0, 0);

    bus(BASE + 16'd5, 1'b1, 1, 8'hA5, 1'b0, 0);
    bus(BASE + 16'd5, 1'b1, 0, '0, 1'b0, 0);

    bus(BASE + AW'(DEPTH), 1'b1, 1, 8'h3C, 1'b0, 0);
    bus(BASE - 16'd1, 1'b1, 1, 8'h3D, 1'b0, 0);
    bus(BASE + 16'd5, 1'b0, 1, 8'h5A, 1'b0, 0);
    bus(BASE + 16'd5, 1'b1, 0, '0, 1'b0, 0);

    bus(BASE + 16'd9, 1'b1, 1, 8'h77, 1'b0, 4);
    bus(BASE + 16'd9, 1'b1, 0, '0, 1'b0, 0);

    bus(BASE + 16'd5, 1'b1, 2, '0, 1'b0, 0);
    bus(BASE + 16'd7, 1'b1, 1, 8'h12, 1'b0, 0);
    bus(BASE + 16'd7, 1'b1, 0, '0, 1'b0, 0);
    do_reset();
    bus(BASE + 16'd5, 1'b1, 0, '0, 1'b0, 0);

    bus(BASE + 16'd6, 1'b1, 1, 8'h44, 1'b1, 0);
    bus(BASE + 16'd6, 1'b1, 0, '0, 1'b0, 0);
    do_reset();

    // ALE held into T2 aborts; the next edge reclaims with the new index
    bus(BASE + 16'd3, 1'b1, 1, 8'h6B, 1'b0, 0);
    ALE = 1'b1; IOM = 1'b1; Address = BASE + 16'd1;
    @(negedge CLK);
    chk("abort_t2", BUSY, 1);
    Address = BASE + 16'd3;
    @(negedge CLK);
    chk("abort_t1", BUSY, 0);
    @(negedge CLK);
    chk("reclaim_t2", BUSY, 1);
    ALE = 1'b0; RD = 1'b0;
    w = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK); #1;
      if (READY) break;
      w++;
    end
    chk("reclaim_waits", w, EXP_W);
    chk("reclaim_data", Data, mem[3]);
    @(negedge CLK);
    RD = 1'b1;
    @(negedge CLK);
    chk("reclaim_idle", BUSY, 0);

    // Reset in the middle of a read
    ALE = 1'b1; IOM = 1'b1; Address = BASE + 16'd3;
    @(negedge CLK);
    ALE = 1'b0; RD = 1'b0;
    @(negedge CLK); #1;
    chk("mid_ready", READY, EXP_W > 0 ? 0 : 1);
    chk("mid_data", Data, EXP_W > 0 ? FLOAT : mem[3]);
    RESET_N = 1'b0; #1;
    chk("mid_rst_data", Data, FLOAT);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_ready", READY, 1);
    model_reset();
    idle();
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    bus(BASE + 16'd3, 1'b1, 0, '0, 1'b0, 0);

    a = BASE + AW'(DEPTH - 1);
    bus(a, 1'b1, 1, 8'hC3, 1'b0, 0);
    bus(a, 1'b1, 0, '0, 1'b0, 0);

    for (int n = 0; n < 80; n++) begin
      int r, k;
      r = $urandom_range(0, 9);
      if (r < 7)
        a = BASE + AW'($urandom_range(0, DEPTH - 1));
      else if (r == 7)
        a = BASE + AW'(DEPTH + $urandom_range(0, 3));
      else if (r == 8)
        a = BASE - AW'($urandom_range(1, 4));
      else
        a = 16'($urandom);
      k = ($urandom_range(0, 19) == 0) ? 2 : $urandom_range(0, 1);
      bus(a, $urandom_range(0, 9) != 0, k,
          8'($urandom_range(0, 254)),
          $urandom_range(0, 15) == 0, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
